// File: rtl/bus_uart_tx_pkg.sv
// Shared definitions for the bus-attached UART transmitter.
//   - Register word indices, decoded from bus_addr[3:2]
//   - STATUS bit positions
//   - Transmit FSM state encoding
//   - Frame constant (data bits per 8N1 frame)
package bus_uart_tx_pkg;

    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_BAUDDIV = 2'd2;

    localparam int unsigned STATUS_FULL  = 0;
    localparam int unsigned STATUS_EMPTY = 1;
    localparam int unsigned STATUS_BUSY  = 2;
    localparam int unsigned STATUS_OVF   = 3;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with first-word-fall-through output.
//   clk, rst : clock and synchronous active-high reset (flushes contents)
//   push,din : write request and data; accepted when not full or when popping
//   pop      : read request; ignored when empty
//   dout     : head entry, valid whenever empty is low
//   level    : entry count, 0..DEPTH
//   full     : level == DEPTH
//   empty    : level == 0
module uart_tx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign pop_ok  = pop & ~empty;
    // When full, a same-cycle pop frees the head slot, which is also the write slot.
    assign push_ok = push & (~full | pop_ok);
    assign dout    = mem_q[rd_ptr_q];
    assign level   = level_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_ok && !pop_ok) begin
            level_d = level_q + LVL_W'(1);
        end else if (!push_ok && pop_ok) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter.
//   clk, rst      : system clock, synchronous active-high reset
//   sel           : chip select from the address decoder
//   bus_re        : read strobe; bus_rdata is zero unless sel && bus_re
//   bus_we        : byte-lane write strobes
//   bus_addr      : byte address, word index in [3:2]
//   bus_wdata     : write data
//   bus_rdata     : combinational read data
//   uart_tx       : serial output, idle high
//   irq           : high while the FIFO is empty and the transmitter is idle
// Registers: 0 TXDATA (push), 1 STATUS, 2 BAUDDIV (clocks per bit minus one), 3 reserved.
module bus_uart_tx
    import bus_uart_tx_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic        bus_re,
    input  logic [3:0]  bus_we,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        uart_tx,
    output logic        irq
);

    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]       reg_idx;
    logic             push_req;
    logic             push;
    logic             pop;
    logic             ovf_clr;
    logic [7:0]       fifo_dout;
    logic [LVL_W-1:0] fifo_level;
    logic [LVL_W-1:0] level_next;
    logic             fifo_full;
    logic             fifo_empty;
    logic             baud_tick;
    logic [31:0]      status_word;
    logic             unused_bus;

    tx_state_e   state_q, state_d;
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        irq_q, irq_d;
    logic [15:0] baud_div_q, baud_div_d;
    logic        ovf_q, ovf_d;

    assign reg_idx    = bus_addr[3:2];
    assign unused_bus = ^{bus_addr[31:4], bus_addr[1:0], bus_wdata[31:16], bus_we[3:2]};

    assign push_req = sel & bus_we[0] & (reg_idx == REG_TXDATA);
    assign push     = push_req & (~fifo_full | pop);
    assign ovf_clr  = sel & bus_we[0] & (reg_idx == REG_STATUS) & bus_wdata[STATUS_OVF];

    uart_tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (bus_wdata[7:0]),
        .dout  (fifo_dout),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign baud_tick = (baud_cnt_q == '0);

    // Transmit FSM. The line value is registered alongside the state, so each
    // transition also decides what uart_tx shows for the coming bit.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        pop        = 1'b0;
        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_d    = fifo_dout;
                    baud_cnt_d = baud_div_q;
                    state_d    = StStart;
                    tx_d       = 1'b0;
                end
            end
            StStart: begin
                if (baud_tick) begin
                    baud_cnt_d = baud_div_q;
                    bit_cnt_d  = '0;
                    state_d    = StData;
                    tx_d       = shift_q[0];
                end else begin
                    baud_cnt_d = baud_cnt_q - 16'd1;
                end
            end
            StData: begin
                if (baud_tick) begin
                    baud_cnt_d = baud_div_q;
                    if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
                        state_d = StStop;
                        tx_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 16'd1;
                end
            end
            StStop: begin
                if (baud_tick) begin
                    if (!fifo_empty) begin
                        // Chain straight into the next frame with no idle gap.
                        pop        = 1'b1;
                        shift_d    = fifo_dout;
                        baud_cnt_d = baud_div_q;
                        state_d    = StStart;
                        tx_d       = 1'b0;
                    end else begin
                        state_d = StIdle;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Register file next state and post-edge interrupt condition.
    always_comb begin
        baud_div_d = baud_div_q;
        if (sel && (reg_idx == REG_BAUDDIV)) begin
            if (bus_we[0]) begin
                baud_div_d[7:0] = bus_wdata[7:0];
            end
            if (bus_we[1]) begin
                baud_div_d[15:8] = bus_wdata[15:8];
            end
        end

        ovf_d = ovf_q;
        if (push_req && !push) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end

        // irq reflects the FIFO and FSM as they will be after this edge.
        level_next = fifo_level + LVL_W'(push) - LVL_W'(pop);
        irq_d      = (level_next == '0) && (state_d == StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            irq_q      <= 1'b1;
            baud_div_q <= DEFAULT_DIV;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            irq_q      <= irq_d;
            baud_div_q <= baud_div_d;
            ovf_q      <= ovf_d;
        end
    end

    assign uart_tx = tx_q;
    assign irq     = irq_q;

    always_comb begin
        status_word               = '0;
        status_word[STATUS_FULL]  = fifo_full;
        status_word[STATUS_EMPTY] = fifo_empty;
        status_word[STATUS_BUSY]  = ~fifo_empty | (state_q != StIdle);
        status_word[STATUS_OVF]   = ovf_q;
        status_word[15:8]         = 8'(fifo_level);
    end

    always_comb begin
        bus_rdata = '0;
        if (sel && bus_re) begin
            case (reg_idx)
                REG_STATUS:  bus_rdata = status_word;
                REG_BAUDDIV: bus_rdata = {16'h0000, baud_div_q};
                default:     bus_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_uart_tx.sv
module tb_bus_uart_tx;

    localparam logic [31:0] A_TXDATA = 32'h0;
    localparam logic [31:0] A_STATUS = 32'h4;
    localparam logic [31:0] A_BAUD   = 32'h8;
    localparam logic [31:0] A_RSVD   = 32'hC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        bus_re = 1'b0;
    logic [3:0]  bus_we = 4'b0;
    logic [31:0] bus_addr = '0;
    logic [31:0] bus_wdata = '0;
    logic [31:0] bus_rdata;
    logic        uart_tx;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;

    // Scoreboard: bytes expected on the line, in order.
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    bus_uart_tx #(
        .FIFO_DEPTH  (16),
        .DEFAULT_DIV (16'd433)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sel       (sel),
        .bus_re    (bus_re),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .uart_tx   (uart_tx),
        .irq       (irq)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time expired, required completion");
        $fatal(1, "watchdog");
    end

    // One-cycle bus write, started and finished on a falling edge.
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] we, input logic s = 1'b1);
        sel       = s;
        bus_re    = 1'b0;
        bus_we    = we;
        bus_addr  = addr;
        bus_wdata = data;
        @(negedge clk);
        sel    = 1'b0;
        bus_we = 4'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] d);
        sel      = 1'b1;
        bus_re   = 1'b1;
        bus_addr = addr;
        #1;
        d      = bus_rdata;
        sel    = 1'b0;
        bus_re = 1'b0;
    endtask

    task automatic tx_byte(input logic [7:0] b);
        exp_q.push_back(b);
        bus_write(A_TXDATA, {24'h0, b}, 4'b0001);
    endtask

    // Receive one frame against the scoreboard head; bits before index sw last d0
    // cycles, later bits d1 cycles. Every cycle of every bit is checked.
    task automatic check_frame(input string name, input int d0, input int d1, input int sw,
                               output int waited);
        logic [7:0] exp_b;
        logic [7:0] got_b;
        logic       exp_bit;
        logic       bit_ok;
        logic       mid;
        int         dur;
        waited = 0;
        while (uart_tx !== 1'b0 && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        if (uart_tx !== 1'b0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s start: line=%b, required 0 within 3000 cycles", name, uart_tx);
            return;
        end
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s start: frame seen, required no frame (scoreboard empty)", name);
            return;
        end
        exp_b = exp_q.pop_front();
        got_b = '0;
        for (int b = 0; b < 10; b++) begin
            dur     = (b < sw) ? d0 : d1;
            exp_bit = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : exp_b[b-1];
            bit_ok  = 1'b1;
            mid     = uart_tx;
            for (int c = 0; c < dur; c++) begin
                if (uart_tx !== exp_bit) bit_ok = 1'b0;
                if (c == dur / 2) mid = uart_tx;
                @(negedge clk);
            end
            if (b >= 1 && b <= 8) got_b[b-1] = mid;
            n_cmp++;
            if (!bit_ok) begin
                n_bad++;
                $display("FAIL %s bit%0d: line not steady (mid=%b), required %b for %0d cycles",
                         name, b, mid, exp_bit, dur);
            end
        end
        n_cmp++;
        if (got_b !== exp_b) begin
            n_bad++;
            $display("FAIL %s byte: got %02h, required %02h", name, got_b, exp_b);
        end
    endtask

    task automatic test_reset;
        logic [31:0] d;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (uart_tx !== 1'b1) begin
            n_bad++; $display("FAIL reset uart_tx: got %b, required 1", uart_tx);
        end
        n_cmp++;
        if (irq !== 1'b1) begin
            n_bad++; $display("FAIL reset irq: got %b, required 1", irq);
        end
        n_cmp++;
        if (bus_rdata !== 32'h0) begin
            n_bad++; $display("FAIL reset idle rdata: got %h, required 0", bus_rdata);
        end
        bus_read(A_STATUS, d);
        n_cmp++;
        if (d !== 32'h0000_0002) begin
            n_bad++; $display("FAIL reset status: got %h, required 00000002", d);
        end
        bus_read(A_BAUD, d);
        n_cmp++;
        if (d !== 32'd433) begin
            n_bad++; $display("FAIL reset bauddiv: got %h, required %h", d, 32'd433);
        end
    endtask

    task automatic test_single_frame;
        int          w;
        logic [31:0] d;
        @(negedge clk);
        bus_write(A_BAUD, 32'd3, 4'b0011);
        tx_byte(8'hA5);
        n_cmp++;
        if (uart_tx !== 1'b1) begin
            n_bad++; $display("FAIL single early: uart_tx=%b at write edge, required 1", uart_tx);
        end
        n_cmp++;
        if (irq !== 1'b0) begin
            n_bad++; $display("FAIL single irq busy: got %b, required 0", irq);
        end
        check_frame("single", 4, 4, 10, w);
        n_cmp++;
        if (w !== 1) begin
            n_bad++; $display("FAIL single latency: start after %0d cycles, required 1", w);
        end
        n_cmp++;
        if (irq !== 1'b1 || uart_tx !== 1'b1) begin
            n_bad++; $display("FAIL single end: irq=%b tx=%b, required 1 1", irq, uart_tx);
        end
        bus_read(A_STATUS, d);
        n_cmp++;
        if (d !== 32'h0000_0002) begin
            n_bad++; $display("FAIL single status: got %h, required 00000002", d);
        end
    endtask

    task automatic test_back_to_back;
        int          w1;
        int          w2;
        logic [31:0] d;
        @(negedge clk);
        tx_byte(8'h00);
        tx_byte(8'hFF);
        fork
            check_frame("b2b_first", 4, 4, 10, w1);
            begin
                repeat (10) @(negedge clk);
                bus_read(A_STATUS, d);
                n_cmp++;
                if (d !== 32'h0000_0104) begin
                    n_bad++; $display("FAIL b2b status: got %h, required 00000104", d);
                end
            end
        join
        check_frame("b2b_second", 4, 4, 10, w2);
        n_cmp++;
        if (w2 !== 0) begin
            n_bad++; $display("FAIL b2b gap: %0d idle cycles, required 0", w2);
        end
        n_cmp++;
        if (irq !== 1'b1) begin
            n_bad++; $display("FAIL b2b irq: got %b, required 1", irq);
        end
    endtask

    task automatic test_overflow;
        int          w;
        logic [31:0] d;
        logic [7:0]  b;
        @(negedge clk);
        bus_write(A_BAUD, 32'd100, 4'b0011);
        fork
            for (int k = 0; k < 17; k++) begin
                check_frame("ovf_drain", 101, 101, 10, w);
                if (k > 0) begin
                    n_cmp++;
                    if (w !== 0) begin
                        n_bad++; $display("FAIL ovf gap: frame %0d after %0d idle, required 0", k, w);
                    end
                end
            end
            begin
                for (int i = 0; i < 18; i++) begin
                    b = 8'(i * 13 + 7);
                    // First byte pops at once; 16 fill the FIFO; the 18th is dropped.
                    if (i < 17) exp_q.push_back(b);
                    bus_write(A_TXDATA, {24'h0, b}, 4'b0001);
                end
                bus_read(A_STATUS, d);
                n_cmp++;
                if (d !== 32'h0000_100D) begin
                    n_bad++; $display("FAIL ovf status: got %h, required 0000100D", d);
                end
                @(negedge clk);
                bus_write(A_STATUS, 32'h8, 4'b0001);
                bus_read(A_STATUS, d);
                n_cmp++;
                if (d !== 32'h0000_1005) begin
                    n_bad++; $display("FAIL ovf clear: got %h, required 00001005", d);
                end
            end
        join
        bus_read(A_STATUS, d);
        n_cmp++;
        if (d !== 32'h0000_0002 || irq !== 1'b1) begin
            n_bad++; $display("FAIL ovf drained: status %h irq %b, required 00000002 1", d, irq);
        end
    endtask

    task automatic test_div_change;
        int          w;
        logic [31:0] d;
        @(negedge clk);
        bus_write(A_BAUD, 32'd3, 4'b0011);
        tx_byte(8'h55);
        fork
            check_frame("divchg", 4, 8, 3, w);
            begin
                // Lands inside frame bit 2 (data bit 1), not on a boundary.
                repeat (9) @(negedge clk);
                bus_write(A_BAUD, 32'd7, 4'b0001);
            end
        join
        bus_read(A_BAUD, d);
        n_cmp++;
        if (d !== 32'd7) begin
            n_bad++; $display("FAIL divchg readback: got %h, required 00000007", d);
        end
    endtask

    task automatic test_bus_gating;
        logic [31:0] d;
        logic        line_ok;
        @(negedge clk);
        bus_write(A_BAUD, 32'd3, 4'b0011);
        bus_write(A_TXDATA, 32'h5A, 4'b0001, 1'b0);
        bus_write(A_TXDATA, 32'h5A5A, 4'b0010);
        line_ok = 1'b1;
        repeat (20) begin
            if (uart_tx !== 1'b1) line_ok = 1'b0;
            @(negedge clk);
        end
        n_cmp++;
        if (!line_ok) begin
            n_bad++; $display("FAIL gate line: activity seen, required idle high");
        end
        bus_read(A_STATUS, d);
        n_cmp++;
        if (d !== 32'h0000_0002) begin
            n_bad++; $display("FAIL gate status: got %h, required 00000002", d);
        end
        sel = 1'b1; bus_re = 1'b0; bus_addr = A_STATUS;
        #1;
        n_cmp++;
        if (bus_rdata !== 32'h0) begin
            n_bad++; $display("FAIL gate no_re: got %h, required 0", bus_rdata);
        end
        sel = 1'b0; bus_re = 1'b1; bus_addr = A_BAUD;
        #1;
        n_cmp++;
        if (bus_rdata !== 32'h0) begin
            n_bad++; $display("FAIL gate no_sel: got %h, required 0", bus_rdata);
        end
        bus_re = 1'b0;
        @(negedge clk);
        bus_write(A_BAUD, 32'hFFFF_1234, 4'b1111);
        bus_read(A_BAUD, d);
        n_cmp++;
        if (d !== 32'h0000_1234) begin
            n_bad++; $display("FAIL gate baud full: got %h, required 00001234", d);
        end
        @(negedge clk);
        bus_write(A_BAUD, 32'h0000_5600, 4'b0010);
        bus_write(A_BAUD, 32'h0000_0099, 4'b0001, 1'b0);
        bus_read(A_BAUD, d);
        n_cmp++;
        if (d !== 32'h0000_5634) begin
            n_bad++; $display("FAIL gate baud lane: got %h, required 00005634", d);
        end
        @(negedge clk);
        bus_write(A_RSVD, 32'hFFFF_FFFF, 4'b1111);
        bus_read(A_RSVD, d);
        n_cmp++;
        if (d !== 32'h0) begin
            n_bad++; $display("FAIL gate reserved: got %h, required 0", d);
        end
        bus_read(A_TXDATA, d);
        n_cmp++;
        if (d !== 32'h0) begin
            n_bad++; $display("FAIL gate txdata read: got %h, required 0", d);
        end
        bus_read(A_BAUD, d);
        n_cmp++;
        if (d !== 32'h0000_5634) begin
            n_bad++; $display("FAIL gate reserved alias: baud %h, required 00005634", d);
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [31:0] d;
        logic        line_ok;
        @(negedge clk);
        bus_write(A_BAUD, 32'd3, 4'b0011);
        for (int i = 0; i < 4; i++) begin
            bus_write(A_TXDATA, 32'(8'h31 + i), 4'b0001);
        end
        repeat (5) @(negedge clk);
        bus_read(A_STATUS, d);
        n_cmp++;
        if (d !== 32'h0000_0304) begin
            n_bad++; $display("FAIL rstmid queued: got %h, required 00000304", d);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (uart_tx !== 1'b1 || irq !== 1'b1) begin
            n_bad++; $display("FAIL rstmid outputs: tx %b irq %b, required 1 1", uart_tx, irq);
        end
        bus_read(A_STATUS, d);
        n_cmp++;
        if (d !== 32'h0000_0002) begin
            n_bad++; $display("FAIL rstmid status: got %h, required 00000002", d);
        end
        bus_read(A_BAUD, d);
        n_cmp++;
        if (d !== 32'd433) begin
            n_bad++; $display("FAIL rstmid bauddiv: got %h, required %h", d, 32'd433);
        end
        @(negedge clk);
        line_ok = 1'b1;
        repeat (30) begin
            if (uart_tx !== 1'b1) line_ok = 1'b0;
            @(negedge clk);
        end
        n_cmp++;
        if (!line_ok) begin
            n_bad++; $display("FAIL rstmid flush: line active after reset, required idle");
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_div_change();
        test_bus_gating();
        test_reset_mid_frame();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++; $display("FAIL scoreboard: %0d bytes never sent, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
